// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbiter feeding a one-entry registered output with valid/ready on both sides.
// Define RR_ARB_MUX_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-first priority.
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SW-1:0]      out_sel
);

    logic             load;
    logic             found;
    logic [SW-1:0]    grant;
    logic [WIDTH-1:0] grant_word;

    // The output register can take a new word when empty or being drained this cycle.
    assign load = ~out_valid | out_ready;

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                found = 1'b1;
                grant = i[SW-1:0];
            end
        end
    end
`else
    localparam logic [SW:0] N_EXT = (SW + 1)'(N);

    logic [SW-1:0] ptr;
    logic [N-1:0]  valid_rot;
    logic [SW-1:0] offset;
    logic [SW:0]   grant_sum;

    // Rotate so bit 0 is channel ptr+1; the lowest set bit is the distance to the winner.
    always_comb begin
        valid_rot = N'({in_valid, in_valid} >> ({1'b0, ptr} + (SW + 1)'(1)));
        found     = |valid_rot;
        offset    = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (valid_rot[j]) begin
                offset = j[SW-1:0];
            end
        end
        grant_sum = {1'b0, ptr} + {1'b0, offset} + (SW + 1)'(1);
        if (grant_sum >= N_EXT) begin
            grant_sum = grant_sum - N_EXT;
        end
        grant = grant_sum[SW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= SW'(N - 1);
        end else if (load && found) begin
            ptr <= grant;
        end
    end
`endif

    always_comb begin
        in_ready   = '0;
        grant_word = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == i[SW-1:0]) begin
                in_ready[i] = rst_n & load & found;
                grant_word  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            out_valid <= found;
            if (found) begin
                out_data <= grant_word;
                out_sel  <= grant;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: table-driven grant sequence plus reset, stall and single-channel cases.
// Expected output words are queued when the bench drives an accepting cycle and compared as the DUT presents them.
module tb_rr_arb_mux;

    localparam int WIDTH = 32;
    localparam int N     = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         out_sel;

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
    );

    typedef struct {
        logic [N-1:0] valid;
        logic         ordy;
        logic [N-1:0] exp_rdy;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [1:0]       sel;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[24];
    int   checks     = 0;
    int   failures   = 0;
    int   step_no    = 0;
    logic force_beef = 1'b0;

    function automatic logic [WIDTH-1:0] word(input int ch, input int s);
        return {s[7:0], 8'hA5, ch[7:0], 8'h5A};
    endfunction

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", name, step_no, act, req);
        end
    endtask

    // Called just after a rising edge: drive, sample mid-cycle, update scoreboard, advance one clock.
    task automatic drive_step(input logic [N-1:0] v, input logic ordy, input logic [N-1:0] exp_rdy);
        logic exp_vld;
        exp_t e;
        in_valid  = v;
        out_ready = ordy;
        for (int i = 0; i < N; i++) begin
            in_data[i*WIDTH +: WIDTH] = (force_beef && i == 2) ? 32'hDEADBEEF : word(i, step_no);
        end
        #2;
        exp_vld = (exp_q.size() != 0);
        chk("out_valid", WIDTH'(out_valid), WIDTH'(exp_vld));
        if (exp_vld) begin
            chk("out_data", out_data, exp_q[0].data);
            chk("out_sel", WIDTH'(out_sel), WIDTH'(exp_q[0].sel));
        end
        chk("in_ready", WIDTH'(in_ready), WIDTH'(exp_rdy));
        if (exp_vld && ordy) begin
            void'(exp_q.pop_front());
        end
        for (int i = 0; i < N; i++) begin
            if (exp_rdy[i]) begin
                e.data = in_data[i*WIDTH +: WIDTH];
                e.sel  = 2'(i);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        step_no++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Full rotation, pointer wrap, lone-channel repeat, idle, then a five-cycle stall.
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0100};
        tbl[7]  = '{4'b1111, 1'b1, 4'b1000};
        tbl[8]  = '{4'b1001, 1'b1, 4'b0001};
        tbl[9]  = '{4'b1001, 1'b1, 4'b1000};
        tbl[10] = '{4'b1001, 1'b1, 4'b0001};
        tbl[11] = '{4'b0010, 1'b1, 4'b0010};
        tbl[12] = '{4'b0010, 1'b1, 4'b0010};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000};
        tbl[14] = '{4'b0000, 1'b0, 4'b0000};
        tbl[15] = '{4'b1111, 1'b0, 4'b0100};
        tbl[16] = '{4'b1111, 1'b0, 4'b0000};
        tbl[17] = '{4'b1111, 1'b0, 4'b0000};
        tbl[18] = '{4'b1111, 1'b0, 4'b0000};
        tbl[19] = '{4'b1111, 1'b0, 4'b0000};
        tbl[20] = '{4'b1111, 1'b0, 4'b0000};
        tbl[21] = '{4'b1111, 1'b1, 4'b1000};
        tbl[22] = '{4'b1111, 1'b1, 4'b0001};
        tbl[23] = '{4'b0000, 1'b1, 4'b0000};

        rst_n     = 1'b0;
        in_valid  = '1;
        out_ready = 1'b1;
        in_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", WIDTH'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_sel", WIDTH'(out_sel), '0);
        chk("rst_in_ready", WIDTH'(in_ready), '0);
        rst_n = 1'b1;

`ifndef RR_ARB_MUX_FIXED_PRIO_EN
        for (int k = 0; k < 24; k++) begin
            drive_step(tbl[k].valid, tbl[k].ordy, tbl[k].exp_rdy);
        end
`else
        for (int k = 0; k < 8; k++) begin
            drive_step(4'b1111, 1'b1, 4'b0001);
        end
        drive_step(4'b0000, 1'b1, 4'b0000);
`endif

        // Asynchronous reset while a word is held.
        drive_step(4'b0010, 1'b0, 4'b0010);
        chk("held_before_rst", WIDTH'(out_valid), WIDTH'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", WIDTH'(out_valid), '0);
        chk("async_rst_out_data", out_data, '0);
        chk("async_rst_out_sel", WIDTH'(out_sel), '0);
        chk("async_rst_in_ready", WIDTH'(in_ready), '0);
        exp_q.delete();
        in_valid = 4'b1111;
        @(posedge clk);
        #1;
        chk("in_rst_out_valid", WIDTH'(out_valid), '0);
        rst_n = 1'b1;
        drive_step(4'b1111, 1'b1, 4'b0001);
        drive_step(4'b0000, 1'b1, 4'b0000);

        // Single valid channel carrying a known word.
        force_beef = 1'b1;
        drive_step(4'b0100, 1'b1, 4'b0100);
        force_beef = 1'b0;
        chk("beef_out_valid", WIDTH'(out_valid), WIDTH'(1));
        chk("beef_out_data", out_data, 32'hDEADBEEF);
        chk("beef_out_sel", WIDTH'(out_sel), WIDTH'(2));
        drive_step(4'b0000, 1'b1, 4'b0000);
        drive_step(4'b0000, 1'b1, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the data width per channel in bits (legal range 1..64).
REQ-002 The module SHALL have parameter N, default 4, giving the number of input channels (legal range 2..8); SW = $clog2(N).
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 in_valid  input  N  channel i presents a word.
REQ-007 in_ready  output  N  channel i word is accepted this cycle; combinational.
REQ-008 out_data  output  WIDTH  registered selected word.
REQ-009 out_valid  output  1  out_data holds an unconsumed word; registered.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_sel  output  SW  registered index of the channel that supplied out_data.

Function
REQ-012 The block SHALL hold a one-entry output register; a transfer on either side SHALL occur only when valid and ready are both high.
REQ-013 load = ~out_valid | out_ready; when load=0, in_ready SHALL be all-zero.
REQ-014 When load=1, at most one in_ready bit SHALL be high: the bit of the granted channel, which is the first channel with in_valid=1 searching upward (modulo N) from ptr+1.
REQ-015 in_ready SHALL NOT depend on in_data, and SHALL NOT be asserted for a channel whose in_valid is low.
REQ-016 On a grant to channel g, on the next edge: out_data <= word g, out_sel <= g, out_valid <= 1, ptr <= g.
REQ-017 When load=1 and no channel is valid: out_valid <= 0; out_data, out_sel and ptr SHALL hold their values.
REQ-018 Latency SHALL be one cycle from input accept to out_valid; with out_ready held high, throughput SHALL be one word per cycle (simultaneous drain and load is allowed).
REQ-019 While out_valid=1 and out_ready=0, out_data and out_sel SHALL remain stable.
REQ-020 Pointer wrap: a search from ptr = N-1 SHALL start at channel 0; a grant to the only valid channel SHALL be repeated every cycle regardless of ptr.
REQ-021 An input that holds in_valid without in_ready SHALL be granted within N accept opportunities (starvation-free).

Reset
REQ-022 While rst_n=0: out_valid=0, out_data=0, out_sel=0, ptr=N-1, and in_ready=0.
REQ-023 Reset asserted mid-transfer SHALL discard the held word; the first grant after release SHALL search from channel 0.
REQ-024 Deassertion of rst_n is synchronised externally; the block SHALL accept a grant in the first clock cycle after release.

Configuration
REQ-025 Macro RR_ARB_MUX_FIXED_PRIO_EN: when defined, the grant SHALL go to the lowest-index valid channel, and ptr SHALL be removed. REQ-021 does not apply in this build. All other requirements are unchanged.
REQ-026 When RR_ARB_MUX_FIXED_PRIO_EN is undefined, round-robin arbitration per REQ-014/016 SHALL apply; this is the default build.

Verification
REQ-027 Reset, then hold in_valid=4'b1111 and out_ready=1 for 8 cycles -> out_sel sequence is 0,1,2,3,0,1,2,3, and each word is the data of the matching channel.
REQ-028 Set in_valid=4'b0100 and in_data ch2=32'hDEADBEEF -> in_ready=4'b0100, and one cycle later out_valid=1, out_data=32'hDEADBEEF, out_sel=2.
REQ-029 Load one word, hold out_ready=0 for 5 cycles with all inputs valid -> in_ready=0 throughout, and out_data and out_sel are stable; release out_ready -> next grant goes to ptr+1.
REQ-030 Set ptr=3 (last grant channel 3) and in_valid=4'b1001 -> grant goes to ch0, then ch3 on the next accept.
REQ-031 Drive rst_n low while out_valid=1 -> out_valid=0 immediately (asynchronous); after release with in_valid=4'b1111 -> first out_sel=0.
REQ-032 In a build with RR_ARB_MUX_FIXED_PRIO_EN, hold in_valid=4'b1111 with out_ready=1 -> out_sel is 0 every cycle.
